// File: rtl/pipe_pkg.sv
// Shared pipeline types for the EX/MEM register: state encoding, widths and the MEM bundle.
package pipe_pkg;

    localparam int REG_IDX_W = 3;
    localparam int DATA_W    = 16;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [DATA_W-1:0]    addr;
        logic [DATA_W-1:0]    data;
        logic                 en;
        logic                 wr;
        logic                 reg_wr;
        logic [REG_IDX_W-1:0] wr_reg;
        logic                 halt;
    } mem_bundle_t;

    // A bubble zeroes the don't-care fields too, so the MEM view is fully clean.
    function automatic mem_bundle_t bubble();
        return '0;
    endfunction

endpackage

// File: rtl/mem_fwd_detect.sv
// Combinational detect for a store whose data register is loaded by the instruction now in MEM.
module mem_fwd_detect
    import pipe_pkg::*;
(
    input  logic                 incoming_valid,
    input  logic                 ex_mem_en,
    input  logic                 ex_mem_wr,
    input  logic [REG_IDX_W-1:0] ex_store_src,
    input  logic                 cur_valid,
    input  logic                 cur_en,
    input  logic                 cur_wr,
    input  logic                 cur_reg_wr,
    input  logic [REG_IDX_W-1:0] cur_wr_reg,
    output logic                 fwd
);

    logic is_store;
    logic is_load;

    always_comb begin
        is_store = incoming_valid && ex_mem_en && ex_mem_wr;
        is_load  = cur_valid && cur_en && !cur_wr && cur_reg_wr;
        fwd      = is_store && is_load && (cur_wr_reg == ex_store_src);
    end

endmodule

// File: rtl/pipe_dff.sv
// Flop primitive: synchronous active-low reset to zero, then load when enabled.
module pipe_dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall hold, flush bubbles, halt freeze and sticky misalignment error.
// Define EX_MEM_FWD_EN to build the registered memory-to-memory store-data forward select.
module ex_mem_reg
    import pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 ex_valid,
    input  logic [DATA_W-1:0]    ex_alu_out,
    input  logic [DATA_W-1:0]    ex_store_data,
    input  logic [REG_IDX_W-1:0] ex_store_src,
    input  logic                 ex_mem_en,
    input  logic                 ex_mem_wr,
    input  logic                 ex_reg_wr,
    input  logic [REG_IDX_W-1:0] ex_wr_reg,
    input  logic                 ex_halt,
    output logic                 mem_valid,
    output logic [DATA_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_data,
    output logic                 mem_en,
    output logic                 mem_wr,
    output logic                 mem_reg_wr,
    output logic [REG_IDX_W-1:0] mem_wr_reg,
    output logic                 mem_halt,
    output logic                 mem_mem_fwd,
    output logic                 err
);

    mem_bundle_t cur;
    mem_bundle_t nxt;
    state_t      state;
    state_t      state_nxt;
    logic        state_q;
    logic        load_ex;
    logic        err_nxt;
    logic        hold_n;

    assign hold_n = ~stall;
    assign state  = state_t'(state_q);

    // Once halted, every load is a bubble regardless of EX activity.
    always_comb begin
        load_ex = (state == RUN) && !flush && ex_valid;
        nxt     = bubble();
        if (load_ex) begin
            nxt.valid  = 1'b1;
            nxt.addr   = ex_alu_out;
            nxt.data   = ex_store_data;
            nxt.en     = ex_mem_en;
            nxt.wr     = ex_mem_wr;
            nxt.reg_wr = ex_reg_wr;
            nxt.wr_reg = ex_wr_reg;
            nxt.halt   = ex_halt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (load_ex && ex_halt) state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        err_nxt = err || (load_ex && ex_mem_en && ex_alu_out[0]);
    end

    pipe_dff #(.W($bits(mem_bundle_t))) u_bundle_ff (
        .clk (clk),
        .rst (rst),
        .en  (hold_n),
        .d   (nxt),
        .q   (cur)
    );

    pipe_dff #(.W(1)) u_state_ff (
        .clk (clk),
        .rst (rst),
        .en  (hold_n),
        .d   (state_nxt),
        .q   (state_q)
    );

    pipe_dff #(.W(1)) u_err_ff (
        .clk (clk),
        .rst (rst),
        .en  (hold_n),
        .d   (err_nxt),
        .q   (err)
    );

`ifdef EX_MEM_FWD_EN
    logic fwd_nxt;

    mem_fwd_detect u_fwd_detect (
        .incoming_valid (load_ex),
        .ex_mem_en      (ex_mem_en),
        .ex_mem_wr      (ex_mem_wr),
        .ex_store_src   (ex_store_src),
        .cur_valid      (cur.valid),
        .cur_en         (cur.en),
        .cur_wr         (cur.wr),
        .cur_reg_wr     (cur.reg_wr),
        .cur_wr_reg     (cur.wr_reg),
        .fwd            (fwd_nxt)
    );

    pipe_dff #(.W(1)) u_fwd_ff (
        .clk (clk),
        .rst (rst),
        .en  (hold_n),
        .d   (fwd_nxt),
        .q   (mem_mem_fwd)
    );
`else
    // Without forwarding the hazard unit stalls dependent stores, so the source index goes unused.
    logic unused_store_src;
    assign unused_store_src = ^ex_store_src;
    assign mem_mem_fwd      = 1'b0;
`endif

    always_comb begin
        mem_valid  = cur.valid;
        mem_addr   = cur.addr;
        mem_data   = cur.data;
        mem_en     = cur.en;
        mem_wr     = cur.wr;
        mem_reg_wr = cur.reg_wr;
        mem_wr_reg = cur.wr_reg;
        mem_halt   = cur.halt;
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for ex_mem_reg; forward expectations follow EX_MEM_FWD_EN.
module tb_ex_mem_reg;

`ifdef EX_MEM_FWD_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [15:0] ex_alu_out;
    logic [15:0] ex_store_data;
    logic [2:0]  ex_store_src;
    logic        ex_mem_en;
    logic        ex_mem_wr;
    logic        ex_reg_wr;
    logic [2:0]  ex_wr_reg;
    logic        ex_halt;
    logic        mem_valid;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_en;
    logic        mem_wr;
    logic        mem_reg_wr;
    logic [2:0]  mem_wr_reg;
    logic        mem_halt;
    logic        mem_mem_fwd;
    logic        err;

    int check_count = 0;
    int error_count = 0;

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_alu_out    (ex_alu_out),
        .ex_store_data (ex_store_data),
        .ex_store_src  (ex_store_src),
        .ex_mem_en     (ex_mem_en),
        .ex_mem_wr     (ex_mem_wr),
        .ex_reg_wr     (ex_reg_wr),
        .ex_wr_reg     (ex_wr_reg),
        .ex_halt       (ex_halt),
        .mem_valid     (mem_valid),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_en        (mem_en),
        .mem_wr        (mem_wr),
        .mem_reg_wr    (mem_reg_wr),
        .mem_wr_reg    (mem_wr_reg),
        .mem_halt      (mem_halt),
        .mem_mem_fwd   (mem_mem_fwd),
        .err           (err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] addr, input logic [15:0] data,
                                 input logic [2:0] src, input logic men, input logic mwr,
                                 input logic rwr, input logic [2:0] wreg, input logic halt);
        ex_valid      = valid;
        ex_alu_out    = addr;
        ex_store_data = data;
        ex_store_src  = src;
        ex_mem_en     = men;
        ex_mem_wr     = mwr;
        ex_reg_wr     = rwr;
        ex_wr_reg     = wreg;
        ex_halt       = halt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b1, 16'h0021, 16'hAAAA, 3'd1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);

        // Reset held two cycles with a valid misaligned store at EX
        tick();
        tick();
        checkOutput("rst_valid", mem_valid, 0);
        checkOutput("rst_addr",  mem_addr,  0);
        checkOutput("rst_data",  mem_data,  0);
        checkOutput("rst_en",    mem_en,    0);
        checkOutput("rst_wr",    mem_wr,    0);
        checkOutput("rst_err",   err,       0);
        checkOutput("rst_halt",  mem_halt,  0);
        checkOutput("rst_fwd",   mem_mem_fwd, 0);

        // Load R3 from 0x0040 on the first edge after release
        rst = 1'b1;
        applyStimulus(1'b1, 16'h0040, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
        tick();
        checkOutput("ld_valid",  mem_valid,  1);
        checkOutput("ld_addr",   mem_addr,   16'h0040);
        checkOutput("ld_en",     mem_en,     1);
        checkOutput("ld_wr",     mem_wr,     0);
        checkOutput("ld_reg_wr", mem_reg_wr, 1);
        checkOutput("ld_wr_reg", mem_wr_reg, 3);

        // Store of R3 right behind the load
        applyStimulus(1'b1, 16'h0050, 16'h1234, 3'd3, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        checkOutput("fwd_hit",     mem_mem_fwd, FWD_ON);
        checkOutput("fwd_st_wr",   mem_wr,      1);
        checkOutput("fwd_st_data", mem_data,    16'h1234);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        checkOutput("fwd_drop", mem_mem_fwd, 0);

        // Store of R2 behind a load of R3
        applyStimulus(1'b1, 16'h0040, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0052, 16'h5555, 3'd2, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        checkOutput("fwd_other_reg", mem_mem_fwd, 0);

        // Load of R3 flushed, then store of R3
        applyStimulus(1'b1, 16'h0040, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_ld_valid", mem_valid, 0);
        applyStimulus(1'b1, 16'h0054, 16'h6666, 3'd3, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        checkOutput("fwd_flushed_ld", mem_mem_fwd, 0);

        // Stall hold: store 0x0010/0xBEEF held while EX changes
        applyStimulus(1'b1, 16'h0010, 16'hBEEF, 3'd1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        checkOutput("st_addr0", mem_addr, 16'h0010);
        checkOutput("st_data0", mem_data, 16'hBEEF);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h0020 + 16'(i), 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0);
            tick();
            checkOutput($sformatf("stall_addr%0d", i), mem_addr, 16'h0010);
            checkOutput($sformatf("stall_data%0d", i), mem_data, 16'hBEEF);
        end
        stall = 1'b0;
        applyStimulus(1'b1, 16'h0020, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0);
        tick();
        checkOutput("post_stall_addr", mem_addr, 16'h0020);
        checkOutput("post_stall_wr",   mem_wr,   0);

        // Forward select held through a stall
        applyStimulus(1'b1, 16'h0060, 16'h7777, 3'd4, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        checkOutput("fwd_pre_stall", mem_mem_fwd, FWD_ON);
        stall = 1'b1;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        checkOutput("fwd_stall1", mem_mem_fwd, FWD_ON);
        tick();
        checkOutput("fwd_stall2", mem_mem_fwd, FWD_ON);
        checkOutput("fwd_stall_v", mem_valid, 1);
        stall = 1'b0;

        // Flush with stall holds, flush alone bubbles
        applyStimulus(1'b1, 16'h0030, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0);
        tick();
        flush = 1'b1;
        stall = 1'b1;
        applyStimulus(1'b1, 16'h0032, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0);
        tick();
        checkOutput("fs_hold_valid", mem_valid, 1);
        checkOutput("fs_hold_addr",  mem_addr,  16'h0030);
        stall = 1'b0;
        tick();
        checkOutput("fs_bub_valid", mem_valid, 0);
        checkOutput("fs_bub_en",    mem_en,    0);
        checkOutput("fs_bub_addr",  mem_addr,  0);
        flush = 1'b0;

        // Misaligned address on a flushed access does not set err
        flush = 1'b1;
        applyStimulus(1'b1, 16'h0005, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0);
        tick();
        flush = 1'b0;
        checkOutput("mis_flushed_err", err, 0);

        // Misaligned load sets sticky err
        applyStimulus(1'b1, 16'h0003, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0);
        tick();
        checkOutput("mis_err",   err,       1);
        checkOutput("mis_valid", mem_valid, 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 16'h0100 + 16'(2 * i), 16'h0000, 3'd0, 1'b1, 1'(i % 2), 1'(1 - i % 2), 3'd2, 1'b0);
            tick();
            checkOutput($sformatf("err_sticky%0d", i), err, 1);
        end

        // Halt arrives during a stall, then latches
        stall = 1'b1;
        applyStimulus(1'b1, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        tick();
        checkOutput("halt_stalled", mem_halt, 0);
        stall = 1'b0;
        tick();
        checkOutput("halt_set",   mem_halt,  1);
        checkOutput("halt_valid", mem_valid, 1);
        applyStimulus(1'b1, 16'h0200, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0);
        tick();
        checkOutput("halt_once",    mem_halt,  0);
        checkOutput("halted_bub_v", mem_valid, 0);
        applyStimulus(1'b1, 16'h0202, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
        tick();
        checkOutput("halted_bub_v2", mem_valid, 0);
        checkOutput("halted_bub_h2", mem_halt,  0);
        checkOutput("halted_bub_en", mem_en,    0);

        // Reset while stalled and halted clears everything
        stall = 1'b1;
        rst   = 1'b0;
        tick();
        checkOutput("rst_stall_err",   err,       0);
        checkOutput("rst_stall_valid", mem_valid, 0);
        stall = 1'b0;
        rst   = 1'b1;
        applyStimulus(1'b1, 16'h0300, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0);
        tick();
        checkOutput("post_rst_valid", mem_valid,  1);
        checkOutput("post_rst_addr",  mem_addr,   16'h0300);
        checkOutput("post_rst_wreg",  mem_wr_reg, 7);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
